// File: rtl/opcode_detect_if.sv
`default_nettype none
// ============================================================================
//  Module      : opcode_detect_if
//  Description : Nibble-in / byte-out bundle for the opcode detector.
//                master  = nibble source (drives din/din_vld, observes dout)
//                slave   = detector      (consumes din/din_vld, drives dout)
//  Signals     : din[3:0]  input nibble, valid when din_vld=1
//                din_vld   nibble qualifier
//                dout[7:0] assembled payload byte
//                dout_vld  one-cycle strobe marking dout valid
//  Revision    : 1.0  initial release
// ============================================================================
interface opcode_detect_if;
    logic [3:0] din;
    logic       din_vld;
    logic [7:0] dout;
    logic       dout_vld;

    modport master (output din, output din_vld, input dout, input dout_vld);
    modport slave  (input din, input din_vld, output dout, output dout_vld);
endinterface
`default_nettype wire

// File: rtl/opcode_detect.sv
`default_nettype none
// ============================================================================
//  Module      : opcode_detect
//  Description : Scans a qualified nibble stream for the sync header
//                HDR_N0..HDR_N3 (default 5,5,D,5), then assembles the next
//                2*PAYLOAD_BYTES nibbles into bytes (high nibble first) and
//                emits each byte with a one-cycle dout_vld strobe.
//  Ports       : clk    system clock, rising edge
//                rst_n  asynchronous reset, ACTIVE-HIGH despite the name
//                bus    opcode_detect_if.slave (din, din_vld in;
//                       dout, dout_vld out)
//  Parameters  : PAYLOAD_BYTES  bytes emitted per header (>= 1)
//                HDR_N0..HDR_N3 header nibbles in arrival order
//  Revision    : 1.0  initial release
// ============================================================================
module opcode_detect #(
    parameter int         PAYLOAD_BYTES = 2,
    parameter logic [3:0] HDR_N0        = 4'h5,
    parameter logic [3:0] HDR_N1        = 4'h5,
    parameter logic [3:0] HDR_N2        = 4'hD,
    parameter logic [3:0] HDR_N3        = 4'h5
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    opcode_detect_if.slave   bus
);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_H1      = 3'd1;
    localparam logic [2:0] c_ST_H2      = 3'd2;
    localparam logic [2:0] c_ST_H3      = 3'd3;
    localparam logic [2:0] c_ST_PAYLOAD = 3'd4;

    localparam int              c_BW        = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam logic [c_BW-1:0] c_LAST_BYTE = c_BW'(PAYLOAD_BYTES - 1);

    logic [2:0]      state_q,    state_d;
    logic            nib_q,      nib_d;      // 0: expecting high nibble, 1: low nibble
    logic [c_BW-1:0] byte_cnt_q, byte_cnt_d;
    logic [3:0]      hi_q,       hi_d;
    logic [7:0]      dout_q,     dout_d;
    logic            dout_vld_q, dout_vld_d;

    // A byte completes when the low nibble of a payload byte is sampled.
    logic w_byte_done;
    assign w_byte_done = (state_q == c_ST_PAYLOAD) && bus.din_vld && nib_q;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q    <= c_ST_IDLE;
            nib_q      <= 1'b0;
            byte_cnt_q <= '0;
            hi_q       <= 4'h0;
            dout_q     <= 8'h00;
            dout_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            nib_q      <= nib_d;
            byte_cnt_q <= byte_cnt_d;
            hi_q       <= hi_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic (header matcher + payload counters)
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        nib_d      = nib_q;
        byte_cnt_d = byte_cnt_q;
        hi_d       = hi_q;
        if (bus.din_vld) begin
            case (state_q)
                c_ST_IDLE: state_d = (bus.din == HDR_N0) ? c_ST_H1 : c_ST_IDLE;
                c_ST_H1:   state_d = (bus.din == HDR_N1) ? c_ST_H2 : c_ST_IDLE;
                c_ST_H2: begin
                    if (bus.din == HDR_N2)
                        state_d = c_ST_H3;
                    // A repeated first nibble keeps the last two nibbles a
                    // valid header prefix, so the match is not lost.
                    else if ((bus.din == HDR_N1) && (HDR_N0 == HDR_N1))
                        state_d = c_ST_H2;
                    else
                        state_d = c_ST_IDLE;
                end
                c_ST_H3: begin
                    if (bus.din == HDR_N3) begin
                        state_d    = c_ST_PAYLOAD;
                        nib_d      = 1'b0;
                        byte_cnt_d = '0;
                    end else begin
                        state_d = c_ST_IDLE;
                    end
                end
                c_ST_PAYLOAD: begin
                    if (!nib_q) begin
                        hi_d  = bus.din;
                        nib_d = 1'b1;
                    end else begin
                        nib_d = 1'b0;
                        if (byte_cnt_q == c_LAST_BYTE) begin
                            state_d    = c_ST_IDLE;
                            byte_cnt_d = '0;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = c_ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic (registered byte + strobe)
    // ------------------------------------------------------------------
    always_comb begin
        dout_d     = dout_q;   // dout holds between strobes
        dout_vld_d = 1'b0;
        if (w_byte_done) begin
            dout_d     = {hi_q, bus.din};
            dout_vld_d = 1'b1;
        end
    end

    assign bus.dout     = dout_q;
    assign bus.dout_vld = dout_vld_q;

endmodule
`default_nettype wire

// File: tb/tb_opcode_detect.sv
`default_nettype none
// ============================================================================
//  Module      : tb_opcode_detect
//  Description : Self-checking bench for opcode_detect (PAYLOAD_BYTES=2).
//                Each vector gives the inputs presented for one clock and
//                the outputs expected just after that clock edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_opcode_detect;

    logic clk;
    logic rst_n;

    opcode_detect_if bus ();

    opcode_detect #(.PAYLOAD_BYTES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       vld;
        logic [3:0] din;
        logic [7:0] exp_dout;
        logic       exp_vld;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic void add(input logic v, input logic [3:0] d,
                                input logic [7:0] ed, input logic ev);
        vec_t r;
        r.vld = v; r.din = d; r.exp_dout = ed; r.exp_vld = ev;
        vecs.push_back(r);
    endfunction

    // One clock: present inputs, sample outputs 1 time unit after the edge.
    task automatic step(input logic v, input logic [3:0] d);
        bus.din_vld = v;
        bus.din     = v ? d : 4'bxxxx;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---- vector table ------------------------------------------------
        // Broken header with gap: 5,5,(D invalid),D,C -> nothing
        add(1, 4'h5, 8'h00, 0); add(1, 4'h5, 8'h00, 0); add(0, 4'hD, 8'h00, 0);
        add(1, 4'hD, 8'h00, 0); add(1, 4'hC, 8'h00, 0);
        // H3 followed by D aborts: 5,5,D,D,5,A -> nothing
        add(1, 4'h5, 8'h00, 0); add(1, 4'h5, 8'h00, 0); add(1, 4'hD, 8'h00, 0);
        add(1, 4'hD, 8'h00, 0); add(1, 4'h5, 8'h00, 0); add(1, 4'hA, 8'h00, 0);
        // Good frame 5,5,D,5,8,1,C,C -> 81, CC
        add(1, 4'h5, 8'h00, 0); add(1, 4'h5, 8'h00, 0); add(1, 4'hD, 8'h00, 0);
        add(1, 4'h5, 8'h00, 0); add(1, 4'h8, 8'h00, 0); add(1, 4'h1, 8'h81, 1);
        add(1, 4'hC, 8'h81, 0); add(1, 4'hC, 8'hCC, 1); add(0, 4'h0, 8'hCC, 0);
        // Overlap 5,5,5,D,5,A,3,4,7 -> A3, 47
        add(1, 4'h5, 8'hCC, 0); add(1, 4'h5, 8'hCC, 0); add(1, 4'h5, 8'hCC, 0);
        add(1, 4'hD, 8'hCC, 0); add(1, 4'h5, 8'hCC, 0); add(1, 4'hA, 8'hCC, 0);
        add(1, 4'h3, 8'hA3, 1); add(1, 4'h4, 8'hA3, 0); add(1, 4'h7, 8'h47, 1);
        add(0, 4'h0, 8'h47, 0);
        // Gaps in header and payload -> 92, 6F
        add(1, 4'h5, 8'h47, 0); add(0, 4'h0, 8'h47, 0); add(1, 4'h5, 8'h47, 0);
        add(1, 4'hD, 8'h47, 0); add(1, 4'h5, 8'h47, 0); add(1, 4'h9, 8'h47, 0);
        add(0, 4'h0, 8'h47, 0); add(0, 4'h0, 8'h47, 0); add(1, 4'h2, 8'h92, 1);
        add(0, 4'h0, 8'h92, 0); add(1, 4'h6, 8'h92, 0); add(1, 4'hF, 8'h6F, 1);
        add(0, 4'h0, 8'h6F, 0);
        // Payload made of header nibbles -> 55, D5, then 7,E must not trigger
        add(1, 4'h5, 8'h6F, 0); add(1, 4'h5, 8'h6F, 0); add(1, 4'hD, 8'h6F, 0);
        add(1, 4'h5, 8'h6F, 0); add(1, 4'h5, 8'h6F, 0); add(1, 4'h5, 8'h55, 1);
        add(1, 4'hD, 8'h55, 0); add(1, 4'h5, 8'hD5, 1);
        add(1, 4'h7, 8'hD5, 0); add(1, 4'hE, 8'hD5, 0);
        // Back-to-back frames: header right after last payload nibble
        add(1, 4'h5, 8'hD5, 0); add(1, 4'h5, 8'hD5, 0); add(1, 4'hD, 8'hD5, 0);
        add(1, 4'h5, 8'hD5, 0); add(1, 4'h1, 8'hD5, 0); add(1, 4'h2, 8'h12, 1);
        add(1, 4'h3, 8'h12, 0); add(1, 4'h4, 8'h34, 1);
        add(1, 4'h5, 8'h34, 0); add(1, 4'h5, 8'h34, 0); add(1, 4'hD, 8'h34, 0);
        add(1, 4'h5, 8'h34, 0); add(1, 4'hB, 8'h34, 0); add(1, 4'hE, 8'hBE, 1);
        add(1, 4'hE, 8'hBE, 0); add(1, 4'hF, 8'hEF, 1); add(0, 4'h0, 8'hEF, 0);

        // ---- reset held for 5 clocks ---------------------------------------
        rst_n       = 1'b1;
        bus.din_vld = 1'b1;
        bus.din     = 4'h5;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check8("reset_dout", bus.dout, 8'h00);
            check1("reset_vld", bus.dout_vld, 1'b0);
        end
        rst_n = 1'b0;
        step(0, 4'h0);
        check8("post_reset_dout", bus.dout, 8'h00);
        check1("post_reset_vld", bus.dout_vld, 1'b0);

        // ---- table ---------------------------------------------------------
        foreach (vecs[i]) begin
            step(vecs[i].vld, vecs[i].din);
            check8($sformatf("vec%0d_dout", i), bus.dout, vecs[i].exp_dout);
            check1($sformatf("vec%0d_vld", i), bus.dout_vld, vecs[i].exp_vld);
        end

        // ---- async reset mid-frame -----------------------------------------
        step(1, 4'h5); step(1, 4'h5); step(1, 4'hD); step(1, 4'h5);
        step(1, 4'hA);
        step(1, 4'hB);
        check8("pre_async_dout", bus.dout, 8'hAB);
        check1("pre_async_vld", bus.dout_vld, 1'b1);
        #1 rst_n = 1'b1;            // between edges
        #1;
        check8("async_rst_dout", bus.dout, 8'h00);
        check1("async_rst_vld", bus.dout_vld, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        // Remaining payload of the aborted frame must not produce a byte.
        bus.din_vld = 1'b1; bus.din = 4'h3;
        @(posedge clk); #1;
        check1("discard_vld0", bus.dout_vld, 1'b0);
        step(1, 4'h4);
        check8("discard_dout", bus.dout, 8'h00);
        check1("discard_vld1", bus.dout_vld, 1'b0);

        // ---- fresh frame after reset works ---------------------------------
        step(1, 4'h5); step(1, 4'h5); step(1, 4'hD); step(1, 4'h5);
        step(1, 4'h0);
        step(1, 4'h9);
        check8("after_rst_dout", bus.dout, 8'h09);
        check1("after_rst_vld", bus.dout_vld, 1'b1);
        step(0, 4'h0);
        check1("after_rst_vld_drop", bus.dout_vld, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/opcode_detect.md
Name: opcode_detect

Overview:
Nibble-stream frame detector for the temperature-monitor datapath. It scans a 4-bit stream qualified by din_vld for the sync header 0x55 0xD5, sent as nibbles 5,5,D,5. After the header it assembles the following nibbles into bytes, high nibble first, and emits PAYLOAD_BYTES bytes (opcode, then data) with a one-cycle valid strobe. It sits between the serial nibble receiver and the command decoder.

Parameters:
PAYLOAD_BYTES, 2, number of bytes emitted per detected header (opcode + data); must be >= 1.
HDR_N0..HDR_N3, 4'h5/4'h5/4'hD/4'h5, header nibble sequence in arrival order.

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst_n  in  1  asynchronous reset, active-high (name kept per codebase convention; asserted = 1 resets immediately, regardless of clk).
din  in  4  input nibble; sampled only when din_vld=1.
din_vld  in  1  nibble qualifier.
dout  out  8  assembled payload byte.
dout_vld  out  1  one-cycle strobe; dout is valid when 1.

Behaviour:
- Reset (rst_n=1, async): state=IDLE, nibble/byte counters=0, dout=8'h00, dout_vld=0. Reset mid-frame discards the partial header/payload.
- Cycles with din_vld=0: no state change, din ignored (value may be X), dout_vld=0.
- Header FSM (advances only on din_vld=1), overlap-aware:
  IDLE: din=5 -> H1; else IDLE.
  H1 (seen 5): din=5 -> H2; else IDLE.
  H2 (seen 5,5): din=D -> H3; din=5 -> H2 (stay, since last two nibbles are still 5,5); else IDLE.
  H3 (seen 5,5,D): din=5 -> PAYLOAD (clear counters); din=D -> IDLE; else IDLE.
- PAYLOAD: each valid nibble is captured; even-indexed nibble = byte[7:4], odd-indexed = byte[3:0].
- On the clock edge sampling the low nibble: dout <= {high_nibble, din}; dout_vld <= 1 for exactly that following cycle.
- Latency: dout/dout_vld registered; they update on the same edge that samples the 2nd nibble and are visible one cycle after that nibble is presented.
- After the PAYLOAD_BYTES-th byte, FSM returns to IDLE on the same edge. Payload nibbles are never interpreted as header (e.g. a payload nibble of 5 does not start a new header).
- Gaps (din_vld=0) inside header or payload are allowed and do not abort the frame.
- dout holds its last value when dout_vld=0; dout_vld is never high for more than one cycle per byte.
- Back-to-back frames: a new header is accepted starting the cycle after the last payload byte is sampled.

Test Plan:
1. Reset: hold rst_n=1 for 5 clocks, release -> dout=8'h00, dout_vld=0 throughout; assert rst_n asynchronously between edges -> outputs clear immediately.
2. Broken header with gap: valid nibbles 5,5, then D with din_vld=0, then valid D, C -> sequence seen is 5,5,D,C; FSM returns to IDLE, no dout_vld pulse.
3. Good frame: valid 5,5,D,5,8,1,C,C on consecutive cycles -> dout=8'h81 with dout_vld=1 one cycle after nibble 1, then dout=8'hCC with dout_vld=1 one cycle after the final C; FSM back in IDLE.
4. Overlap: 5,5,5,D,5,A,3,4,7 -> frame detected; outputs 8'hA3 then 8'h47.
5. Gaps in payload: header, then 9, (vld=0 x2), 2, (vld=0), 6, F -> outputs 8'h92 and 8'h6F; each dout_vld is a single cycle.
6. Payload containing header nibbles: header then 5,5,D,5 as payload -> outputs 8'h55, 8'hD5 only; no re-trigger until the next real header.
